// File: rtl/serial_adder_fsm.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flip-flop produce
// one sum bit per clock, LSB first, and then present the full sum and carry-out.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, bSh_q, result_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bitSum, bitCarry, lastBit;
    logic [WIDTH-1:0] resultNext;

    // The single full-adder cell working on the current LSB pair.
    assign bitSum     = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    assign bitCarry   = (aSh_q[0] & bSh_q[0]) | (carry_q & (aSh_q[0] ^ bSh_q[0]));
    assign lastBit    = (cnt_q == LAST_BIT);
    assign resultNext = (result_q >> 1) | {bitSum, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (lastBit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy/done are decoded from the next state and then registered, so the
    // outputs never see a combinational path from start_i.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSh_q    <= '0;
            bSh_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        aSh_q   <= a_i;
                        bSh_q   <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    aSh_q    <= aSh_q >> 1;
                    bSh_q    <= bSh_q >> 1;
                    result_q <= resultNext;
                    carry_q  <= bitCarry;
                    cnt_q    <= cnt_q + CW'(1);
                    // Visible sum/cout only change on the completing edge.
                    if (lastBit) begin
                        sum_q  <= resultNext;
                        cout_q <= bitCarry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed + randomized bench for serial_adder_fsm at WIDTH=8 and WIDTH=3,
// checked against plain-arithmetic expectations of a+b+cin.
module tb_serial_adder_fsm;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int checks = 0;
    int errors = 0;

    logic [7:0] prevSum8  = 8'h00;
    logic       prevCout8 = 1'b0;
    logic [2:0] prevSum3  = 3'h0;
    logic       prevCout3 = 1'b0;

    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );

    serial_adder_fsm #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .a_i(a3), .b_i(b3),
        .cin_i(cin3), .busy_o(busy3), .done_o(done3), .sum_o(sum3), .cout_o(cout3)
    );

    function automatic logic [8:0] refAdd8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        return 9'(av) + 9'(bv) + 9'(cv);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One WIDTH=8 operation; done must rise after the 8th edge following the
    // start edge. Optionally re-pulses start (with a=0) three cycles in.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                 input bit glitch, input logic [7:0] expSum,
                                 input logic expCout, input string tag);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        checkOutput({tag, "_busy_run"}, 32'(busy8), 32'd1);
        checkOutput({tag, "_sum_held"}, 32'(sum8), 32'(prevSum8));
        checkOutput({tag, "_cout_held"}, 32'(cout8), 32'(prevCout8));
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (glitch && k == 3) begin
                start8 = 1'b1; a8 = 8'h00;
            end
            if (k == 4) start8 = 1'b0;
            checkOutput({tag, "_done_early"}, 32'(done8), 32'd0);
        end
        @(posedge clk); #1;
        checkOutput({tag, "_done"}, 32'(done8), 32'd1);
        checkOutput({tag, "_busy_done"}, 32'(busy8), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum8), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(cout8), 32'(expCout));
        prevSum8  = expSum;
        prevCout8 = expCout;
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, 32'(done8), 32'd0);
        checkOutput({tag, "_busy_idle"}, 32'(busy8), 32'd0);
        checkOutput({tag, "_sum_after"}, 32'(sum8), 32'(prevSum8));
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] ra, rb, dif;
        logic [3:0] r3;
        bit         sawDone;

        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        rst_n  = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_sum", 32'(sum8), 32'd0);
        checkOutput("rst_cout", 32'(cout8), 32'd0);
        checkOutput("rst_sum3", 32'(sum3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 and T2 directed vectors.
        r = refAdd8(8'h5A, 8'h3C, 1'b0);
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "T1");
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "T2a");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "T2b");
        // T3: second start during RUN must be ignored.
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b1, r[7:0], r[8], "T3");

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            r  = refAdd8(ra, rb, i[0]);
            applyStimulus(ra, rb, i[0], 1'b0, r[7:0], r[8], "RND");
        end

        // T4: asynchronous reset four cycles into an operation.
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("T4_busy", 32'(busy8), 32'd0);
        checkOutput("T4_done", 32'(done8), 32'd0);
        checkOutput("T4_sum", 32'(sum8), 32'd0);
        checkOutput("T4_cout", 32'(cout8), 32'd0);
        prevSum8 = 8'h00; prevCout8 = 1'b0;
        prevSum3 = 3'h0;  prevCout3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) sawDone = 1'b1;
        end
        checkOutput("T4_no_done", 32'(sawDone), 32'd0);
        r = refAdd8(8'h77, 8'h11, 1'b1);
        applyStimulus(8'h77, 8'h11, 1'b1, 1'b0, r[7:0], r[8], "T4_after");

        // T5: WIDTH=3 exhaustive, starts spaced exactly WIDTH+2 cycles apart.
        for (int v = 0; v < 128; v++) begin
            @(negedge clk);
            a3 = 3'(v); b3 = 3'(v >> 3); cin3 = 1'(v >> 6); start3 = 1'b1;
            r3 = 4'(a3) + 4'(b3) + 4'(cin3);
            @(posedge clk); #1;
            start3 = 1'b0;
            checkOutput("T5_hold", 32'({cout3, sum3}), 32'({prevCout3, prevSum3}));
            repeat (2) @(posedge clk);
            @(posedge clk); #1;
            checkOutput("T5_done", 32'(done3), 32'd1);
            checkOutput("T5_result", 32'({cout3, sum3}), 32'(r3));
            prevSum3 = r3[2:0]; prevCout3 = r3[3];
            @(posedge clk); #1;
        end

        // T6: adding b back onto a-b recovers a.
        for (int i = 0; i < 12; i++) begin
            ra  = 8'($urandom); rb = 8'($urandom);
            dif = ra - rb;
            r   = refAdd8(dif, rb, 1'b0);
            applyStimulus(dif, rb, 1'b0, 1'b0, ra, r[8], "T6");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
